// File: rtl/mips_multicycle_controller.sv
// Multi-cycle sequencer for the MIPS datapath: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and gates commit strobes to the final cycle(s).
module mips_multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [5:0]             OpCode,
  input  logic [5:0]             funct,
  input  logic                   mem_ready,
  output logic                   RegDst,
  output logic                   Jump,
  output logic                   Branch,
  output logic                   MemRead,
  output logic                   MemToReg,
  output logic                   MemWrite,
  output logic                   ALUSrc,
  output logic                   RegWrite,
  output logic                   Link,
  output logic                   JR,
  output logic                   PC_en,
  output logic [3:0]             ALU_opcode,
  output logic                   instr_done,
  output logic [COUNT_WIDTH-1:0] instr_count,
  output logic                   trap,
  output logic [1:0]             trap_cause,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_JR,
    I_LW, I_SW, I_BEQ, I_ADDI, I_J, I_JAL, I_ILL
  } instr_t;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state;
  instr_t            instr;
  logic [5:0]        op_q;
  logic [5:0]        funct_q;
  logic [WAIT_W-1:0] wait_cnt;

  // Decode only the captured fields so outputs ignore OpCode changes mid-instruction.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    instr = I_ILL;
    case (op_q)
      6'h00: begin
        case (funct_q)
          6'h20:   instr = I_ADD;
          6'h22:   instr = I_SUB;
          6'h24:   instr = I_AND;
          6'h25:   instr = I_OR;
          6'h2A:   instr = I_SLT;
          6'h08:   instr = I_JR;
          default: instr = I_ILL;
        endcase
      end
      6'h23:   instr = I_LW;
      6'h2B:   instr = I_SW;
      6'h04:   instr = I_BEQ;
      6'h08:   instr = I_ADDI;
      6'h02:   instr = I_J;
      6'h03:   instr = I_JAL;
      default: instr = I_ILL;
    endcase
  end

  always_comb begin
    RegDst     = 1'b0;
    Jump       = 1'b0;
    Branch     = 1'b0;
    MemRead    = 1'b0;
    MemToReg   = 1'b0;
    MemWrite   = 1'b0;
    ALUSrc     = 1'b0;
    RegWrite   = 1'b0;
    Link       = 1'b0;
    JR         = 1'b0;
    PC_en      = 1'b0;
    ALU_opcode = 4'b0010;

    if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      case (instr)
        I_ADD:  RegDst = 1'b1;
        I_SUB:  begin RegDst = 1'b1; ALU_opcode = 4'b0110; end
        I_AND:  begin RegDst = 1'b1; ALU_opcode = 4'b0000; end
        I_OR:   begin RegDst = 1'b1; ALU_opcode = 4'b0001; end
        I_SLT:  begin RegDst = 1'b1; ALU_opcode = 4'b0111; end
        I_JR:   begin RegDst = 1'b1; JR = 1'b1; end
        I_LW:   begin ALUSrc = 1'b1; MemToReg = 1'b1; end
        I_SW:   ALUSrc = 1'b1;
        I_BEQ:  begin Branch = 1'b1; ALU_opcode = 4'b0110; end
        I_ADDI: ALUSrc = 1'b1;
        I_J:    Jump = 1'b1;
        I_JAL:  begin Jump = 1'b1; Link = 1'b1; end
        default: ;
      endcase
    end

    case (state)
      S_EXEC: begin
        if (instr inside {I_J, I_JAL, I_JR, I_BEQ}) begin
          PC_en    = 1'b1;
          RegWrite = (instr == I_JAL);
        end
      end
      S_MEM: begin
        MemRead  = (instr == I_LW);
        MemWrite = (instr == I_SW);
        PC_en    = mem_ready && (instr == I_SW);
      end
      S_WB: begin
        RegWrite = 1'b1;
        PC_en    = 1'b1;
        MemRead  = (instr == I_LW);
      end
      default: ;
    endcase

    instr_done = PC_en;
    trap       = (state == S_TRAP);
  end

  assign state_o = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      op_q        <= '0;
      funct_q     <= '0;
      wait_cnt    <= '0;
      trap_cause  <= 2'b00;
      instr_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        S_FETCH: begin
          if (run) begin
            op_q    <= OpCode;
            funct_q <= funct;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (instr == I_ILL) begin
            state      <= S_TRAP;
            trap_cause <= 2'b01;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (instr)
            I_J, I_JAL, I_JR, I_BEQ: state <= S_FETCH;
            I_LW, I_SW: begin
              state    <= S_MEM;
              wait_cnt <= '0;
            end
            default: state <= S_WB;
          endcase
        end
        S_MEM: begin
          // A ready response on the last allowed cycle still completes the access.
          if (mem_ready) begin
            state <= (instr == I_LW) ? S_WB : S_FETCH;
          end else if (MEM_TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
            state      <= S_TRAP;
            trap_cause <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase

      if (instr_done) instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench: per-cycle expected control vectors are queued and
// compared against the controller at each falling edge.
module tb_mips_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [5:0]  OpCode;
  logic [5:0]  funct;
  logic        mem_ready;
  logic        RegDst, Jump, Branch, MemRead, MemToReg, MemWrite;
  logic        ALUSrc, RegWrite, Link, JR, PC_en;
  logic [3:0]  ALU_opcode;
  logic        instr_done;
  logic [31:0] instr_count;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state_o;

  mips_multicycle_controller #(.MEM_TIMEOUT(16), .COUNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .run(run), .OpCode(OpCode), .funct(funct),
    .mem_ready(mem_ready), .RegDst(RegDst), .Jump(Jump), .Branch(Branch),
    .MemRead(MemRead), .MemToReg(MemToReg), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .Link(Link), .JR(JR), .PC_en(PC_en),
    .ALU_opcode(ALU_opcode), .instr_done(instr_done), .instr_count(instr_count),
    .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        reg_dst, jump, branch, mem_read, mem_to_reg, mem_write;
    logic        alu_src, reg_write, link, jr, pc_en;
    logic [3:0]  alu;
    logic        done, trap;
    logic [1:0]  cause;
    logic [31:0] cnt;
  } outv_t;

  localparam int K_JMP = 0, K_ALU = 1, K_LW = 2, K_SW = 3, K_ILL = 4, K_SWTO = 5;

  typedef struct {
    string      name;
    logic [5:0] op, fn;
    int         kind, stalls;
    logic       rd, src, m2r, br, jmp, lnk, jr;
    logic [3:0] alu;
  } vec_t;

  outv_t       q[$];
  vec_t        vecs[$];
  logic [31:0] exp_cnt;
  int          total = 0;
  int          bad = 0;

  function automatic vec_t mk(string name, logic [5:0] op, logic [5:0] fn, int kind,
                              int stalls, logic rd, logic src, logic m2r, logic br,
                              logic jmp, logic lnk, logic jr, logic [3:0] alu);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.kind = kind; v.stalls = stalls;
    v.rd = rd; v.src = src; v.m2r = m2r; v.br = br; v.jmp = jmp; v.lnk = lnk;
    v.jr = jr; v.alu = alu;
    return v;
  endfunction

  function automatic outv_t dut_out();
    outv_t o;
    o.st = state_o; o.reg_dst = RegDst; o.jump = Jump; o.branch = Branch;
    o.mem_read = MemRead; o.mem_to_reg = MemToReg; o.mem_write = MemWrite;
    o.alu_src = ALUSrc; o.reg_write = RegWrite; o.link = Link; o.jr = JR;
    o.pc_en = PC_en; o.alu = ALU_opcode; o.done = instr_done; o.trap = trap;
    o.cause = trap_cause; o.cnt = instr_count;
    return o;
  endfunction

  function automatic outv_t base(logic [2:0] st);
    outv_t e = '0;
    e.st = st; e.alu = 4'b0010; e.cnt = exp_cnt;
    return e;
  endfunction

  function automatic outv_t steered(vec_t v, logic [2:0] st);
    outv_t e = base(st);
    e.reg_dst = v.rd; e.alu_src = v.src; e.mem_to_reg = v.m2r; e.branch = v.br;
    e.jump = v.jmp; e.link = v.lnk; e.jr = v.jr; e.alu = v.alu;
    return e;
  endfunction

  task automatic check(input string name, input outv_t got, input outv_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic cmp_now(input string name);
    outv_t e = q.pop_front();
    check(name, dut_out(), e);
  endtask

  // Queue the expectation for the current cycle, compare at the falling edge.
  task automatic step(input outv_t e, input string name);
    q.push_back(e);
    @(negedge clk);
    cmp_now(name);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    run = 1'b0;
    reset = 1'b0;
    #1;
    exp_cnt = '0;
    q.push_back(base(3'd0));
    cmp_now(name);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    outv_t e;
    OpCode = v.op; funct = v.fn; run = 1'b1; mem_ready = 1'b0;
    step(base(3'd0), {v.name, "/fetch"});
    run = 1'b0;
    step(steered(v, 3'd1), {v.name, "/decode"});
    if (v.kind == K_ILL) begin
      for (int i = 0; i < 4; i++) begin
        e = base(3'd5); e.trap = 1'b1; e.cause = 2'b01;
        step(e, {v.name, "/trap"});
      end
      return;
    end
    e = steered(v, 3'd2);
    if (v.kind == K_JMP) begin e.pc_en = 1'b1; e.done = 1'b1; e.reg_write = v.lnk; end
    step(e, {v.name, "/exec"});
    if (v.kind == K_JMP) begin exp_cnt++; return; end
    if (v.kind == K_ALU) begin
      e = steered(v, 3'd4); e.reg_write = 1'b1; e.pc_en = 1'b1; e.done = 1'b1;
      step(e, {v.name, "/wb"});
      exp_cnt++;
      return;
    end
    for (int i = 0; i < v.stalls; i++) begin
      e = steered(v, 3'd3); e.mem_read = (v.kind == K_LW); e.mem_write = (v.kind != K_LW);
      step(e, {v.name, "/mem_wait"});
    end
    if (v.kind == K_SWTO) begin
      for (int i = 0; i < 100; i++) begin
        e = base(3'd5); e.trap = 1'b1; e.cause = 2'b10;
        step(e, {v.name, "/trap"});
      end
      return;
    end
    mem_ready = 1'b1;
    e = steered(v, 3'd3); e.mem_read = (v.kind == K_LW); e.mem_write = (v.kind == K_SW);
    if (v.kind == K_SW) begin e.pc_en = 1'b1; e.done = 1'b1; end
    step(e, {v.name, "/mem_ready"});
    mem_ready = 1'b0;
    if (v.kind == K_SW) begin exp_cnt++; return; end
    e = steered(v, 3'd4); e.mem_read = 1'b1; e.reg_write = 1'b1; e.pc_en = 1'b1; e.done = 1'b1;
    step(e, {v.name, "/wb"});
    exp_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    outv_t e;
    vec_t  add_v, lw_v;
    //            name     op     fn     kind    st rd src m2r br jmp lnk jr alu
    vecs.push_back(mk("add",  6'h00, 6'h20, K_ALU,  0, 1, 0, 0, 0, 0, 0, 0, 4'b0010));
    vecs.push_back(mk("sub",  6'h00, 6'h22, K_ALU,  0, 1, 0, 0, 0, 0, 0, 0, 4'b0110));
    vecs.push_back(mk("and",  6'h00, 6'h24, K_ALU,  0, 1, 0, 0, 0, 0, 0, 0, 4'b0000));
    vecs.push_back(mk("or",   6'h00, 6'h25, K_ALU,  0, 1, 0, 0, 0, 0, 0, 0, 4'b0001));
    vecs.push_back(mk("slt",  6'h00, 6'h2A, K_ALU,  0, 1, 0, 0, 0, 0, 0, 0, 4'b0111));
    vecs.push_back(mk("addi", 6'h08, 6'h15, K_ALU,  0, 0, 1, 0, 0, 0, 0, 0, 4'b0010));
    vecs.push_back(mk("jr",   6'h00, 6'h08, K_JMP,  0, 1, 0, 0, 0, 0, 0, 1, 4'b0010));
    vecs.push_back(mk("j",    6'h02, 6'h00, K_JMP,  0, 0, 0, 0, 0, 1, 0, 0, 4'b0010));
    vecs.push_back(mk("jal",  6'h03, 6'h2A, K_JMP,  0, 0, 0, 0, 0, 1, 1, 0, 4'b0010));
    vecs.push_back(mk("beq",  6'h04, 6'h20, K_JMP,  0, 0, 0, 0, 1, 0, 0, 0, 4'b0110));
    vecs.push_back(mk("lw2",  6'h23, 6'h00, K_LW,   2, 0, 1, 1, 0, 0, 0, 0, 4'b0010));
    vecs.push_back(mk("sw0",  6'h2B, 6'h00, K_SW,   0, 0, 1, 0, 0, 0, 0, 0, 4'b0010));
    vecs.push_back(mk("lw0",  6'h23, 6'h00, K_LW,   0, 0, 1, 1, 0, 0, 0, 0, 4'b0010));
    vecs.push_back(mk("sw3",  6'h2B, 6'h00, K_SW,   3, 0, 1, 0, 0, 0, 0, 0, 4'b0010));
    vecs.push_back(mk("lw15", 6'h23, 6'h00, K_LW,  15, 0, 1, 1, 0, 0, 0, 0, 4'b0010));
    vecs.push_back(mk("swto", 6'h2B, 6'h00, K_SWTO,16, 0, 1, 0, 0, 0, 0, 0, 4'b0010));
    vecs.push_back(mk("ill3f",6'h3F, 6'h20, K_ILL,  0, 0, 0, 0, 0, 0, 0, 0, 4'b0010));
    vecs.push_back(mk("illr0",6'h00, 6'h00, K_ILL,  0, 0, 0, 0, 0, 0, 0, 0, 4'b0010));
    vecs.push_back(mk("sub2", 6'h00, 6'h22, K_ALU,  0, 1, 0, 0, 0, 0, 0, 0, 4'b0110));
    add_v = vecs[0];
    lw_v  = vecs[10];

    reset = 1'b0; run = 1'b0; OpCode = 6'h00; funct = 6'h20; mem_ready = 1'b0;
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    q.push_back(base(3'd0));
    cmp_now("reset_state");
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) step(base(3'd0), "run0_hold");

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      if (vecs[i].kind == K_ILL || vecs[i].kind == K_SWTO)
        do_reset({vecs[i].name, "/reset"});
    end

    // Reset dropped while WB is committing.
    run_vec(add_v);
    OpCode = add_v.op; funct = add_v.fn; run = 1'b1;
    step(base(3'd0), "mid_wb/fetch");
    run = 1'b0;
    step(steered(add_v, 3'd1), "mid_wb/decode");
    step(steered(add_v, 3'd2), "mid_wb/exec");
    e = steered(add_v, 3'd4); e.reg_write = 1'b1; e.pc_en = 1'b1; e.done = 1'b1;
    q.push_back(e);
    cmp_now("mid_wb/wb");
    do_reset("mid_wb/reset");

    // Reset dropped while a load waits in MEM.
    OpCode = lw_v.op; funct = lw_v.fn; run = 1'b1; mem_ready = 1'b0;
    step(base(3'd0), "mid_mem/fetch");
    run = 1'b0;
    step(steered(lw_v, 3'd1), "mid_mem/decode");
    step(steered(lw_v, 3'd2), "mid_mem/exec");
    e = steered(lw_v, 3'd3); e.mem_read = 1'b1;
    step(e, "mid_mem/mem");
    do_reset("mid_mem/reset");
    step(base(3'd0), "post_reset_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Multi-cycle sequencing controller for the single-cycle MIPS datapath. It reads `OpCode`/`funct` from the datapath, walks each instruction through FETCH/DECODE/EXEC/MEM/WB, and drives every datapath control input. Commit strobes (`PC_en`, `RegWrite`, `MemWrite`) fire only in the instruction's final cycle(s). A ready handshake lets data memory stall loads and stores, with a timeout trap.

## Interface
- `MEM_TIMEOUT`, 16: max MEM cycles waiting for `mem_ready`. 0 disables the timeout.
- `COUNT_WIDTH`, 32: width of the retired-instruction counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (asserted at 0).
- `run`  in  1  permits leaving FETCH. Sampled only in FETCH.
- `OpCode`  in  6  instruction opcode from the datapath.
- `funct`  in  6  R-type function field from the datapath.
- `mem_ready`  in  1  data memory done. Sampled only in MEM.
- `RegDst`, `Jump`, `Branch`, `MemRead`, `MemToReg`, `MemWrite`, `ALUSrc`, `RegWrite`, `Link`, `JR`, `PC_en`  out  1 each  datapath controls.
- `ALU_opcode`  out  4  ALU operation code.
- `instr_done`  out  1  pulse in the cycle an instruction retires; equals `PC_en`.
- `instr_count`  out  COUNT_WIDTH  retired instructions, wraps modulo 2^COUNT_WIDTH.
- `trap`  out  1  controller halted.
- `trap_cause`  out  2  00 none, 01 illegal instruction, 10 memory timeout.
- `state_o`  out  3  encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

## Operation
- **Supported instructions.**
  - R-type (op 000000): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08.
  - Other opcodes: lw 100011, sw 101011, beq 000100, addi 001000, j 000010, jal 000011.
  - Anything else, including R-type with another funct, is illegal.
- **Decoding.** `OpCode`/`funct` are registered on leaving FETCH. All decoding uses the registered copy.
- **ALU_opcode.** add/addi/lw/sw → 0010, sub/beq → 0110, and → 0000, or → 0001, slt → 0111.
- **Steering signals** (`RegDst`, `ALUSrc`, `ALU_opcode`, `MemToReg`, `Branch`, `Jump`, `JR`, `Link`):
  - Valid and constant from DECODE through the instruction's last cycle.
  - All 0 (`ALU_opcode` 0010) in FETCH and TRAP.
  - `RegDst`=1 for R-type. `ALUSrc`=1 for addi/lw/sw. `MemToReg`=1 for lw. `Branch`=1 for beq. `Jump`=1 for j/jal. `Link`=1 for jal. `JR`=1 for jr.
- **FETCH.** `run`=1: capture fields, go to DECODE. Otherwise stay.
- **DECODE.** Illegal instruction → TRAP with cause 01. Otherwise → EXEC.
- **EXEC.**
  - j/jal/jr/beq: `PC_en`=1 and `instr_done`=1 for this one cycle, with `RegWrite`=1 for jal only; → FETCH.
  - R-type ALU ops and addi → WB.
  - lw/sw → MEM, clearing the wait counter.
- **MEM.** `MemRead`=1 (lw) or `MemWrite`=1 (sw) for every MEM cycle.
  - `mem_ready`=1 with lw: → WB.
  - `mem_ready`=1 with sw: `PC_en`=`instr_done`=1 this cycle; → FETCH.
  - `mem_ready`=0: wait counter increments.
  - Counter reaches MEM_TIMEOUT−1 with `mem_ready` still 0 (MEM_TIMEOUT≠0): → TRAP with cause 10. Ready on that same final cycle wins over timeout.
- **WB.** `RegWrite`=1, `PC_en`=1, `instr_done`=1 for one cycle; lw also holds `MemRead`=1; → FETCH.
- **TRAP.** Absorbing; only reset exits.
  - `trap`=1, `trap_cause` held.
  - Every commit output and `MemRead` is 0.
- **Commit rule.** `RegWrite` and `PC_en` are never high in any other state/cycle.
- **Counter.** `instr_count` increments on each edge where `instr_done`=1.

## Timing
- **Reset.** Asserting `reset` at 0, at any time including mid-MEM or mid-WB, immediately (combinationally) produces:
  - state FETCH, all controls 0, `ALU_opcode` 0010;
  - `instr_count` 0, `trap` 0, `trap_cause` 00.
  - Deassertion takes effect at the next rising edge.
- **Cycles per instruction,** with `run`=1 throughout:
  - j/jal/jr/beq: 3.
  - R-type ALU ops and addi: 4.
  - sw: 4+W. lw: 5+W. W = cycles with `mem_ready`=0 before the ready cycle.
- **Output generation.** All outputs are a function of registered state and registered fields only. They are glitch-free relative to `OpCode`, which changes right after the `PC_en` edge.
- **FETCH latency.** Minimum one cycle, so the instruction read from the new PC settles before capture.

## Test plan
- **add.** add (op 0, funct 0x20), `run`=1 → `RegDst`=1 and `ALU_opcode`=0010 from cycle 2. `RegWrite`=`PC_en`=1 only in cycle 4 (WB). `instr_count` 0→1.
- **lw with stalls.** lw, `mem_ready` high on the 3rd MEM cycle → `MemRead`=1 for cycles 4–7. WB in cycle 7 with `MemToReg`=`RegWrite`=`PC_en`=1. Total 7 cycles.
- **beq and jal.**
  - beq → `Branch`=1, `ALU_opcode`=0110, `PC_en` only in cycle 3, `RegWrite`=0 throughout.
  - jal → `Jump`=`Link`=`RegWrite`=`PC_en`=1 in cycle 3.
- **sw timeout.** sw with `mem_ready`=0, MEM_TIMEOUT=16 → `MemWrite`=1 for 16 cycles, then `trap`=1, `trap_cause`=10, `MemWrite`=0. `PC_en` never asserted. State stays TRAP for 100 cycles.
- **Illegal instruction.** op 0x3F → `trap_cause`=01 entered after DECODE (cycle 3), no commit strobes. R-type funct 0x00 gives the same result.
- **Async reset and run gating.**
  - Drop `reset` mid-WB → `RegWrite`/`PC_en` fall in the same timestep; `instr_count`=0; state_o=0.
  - `run`=0 holds FETCH indefinitely with all outputs 0.
